// File: rtl/multi_ball_if.sv
// Sprite bus between the video/keyboard side and the multi-ball motion block.
// Signal names follow the existing vga_controller / color_mapper hookup.
interface multi_ball_if #(
  parameter int unsigned N_BALLS = 4,
  parameter int unsigned W       = 10
);
  localparam int unsigned SEL_W = $clog2(N_BALLS);

  logic                 vs;
  logic [7:0]           keycode;
  logic [W-1:0]         DrawX;
  logic [W-1:0]         DrawY;
  logic [N_BALLS*W-1:0] BallX;
  logic [N_BALLS*W-1:0] BallY;
  logic [W-1:0]         BallS;
  logic [SEL_W-1:0]     sel;
  logic                 hit;
  logic [SEL_W-1:0]     hit_id;

  modport master (
    output vs, keycode, DrawX, DrawY,
    input  BallX, BallY, BallS, sel, hit, hit_id
  );

  modport slave (
    input  vs, keycode, DrawX, DrawY,
    output BallX, BallY, BallS, sel, hit, hit_id
  );
endinterface

// File: rtl/multi_ball.sv
// Per-frame motion for N_BALLS sprites: keyboard steering of the selected ball,
// edge bounce for all balls, and a registered pixel hit-test for the color mapper.
module multi_ball #(
  parameter int unsigned N_BALLS = 4,
  parameter int unsigned W       = 10,
  parameter int unsigned X_MIN   = 0,
  parameter int unsigned X_MAX   = 639,
  parameter int unsigned Y_MIN   = 0,
  parameter int unsigned Y_MAX   = 479,
  parameter int unsigned BALL_S  = 4,
  parameter int unsigned STEP    = 1
) (
  input  logic          Clk,
  input  logic          Reset,
  multi_ball_if.slave   bus
);
  localparam int unsigned SEL_W = $clog2(N_BALLS);

  localparam logic [W:0]        BS_E   = (W+1)'(BALL_S);
  localparam logic [W:0]        XMIN_E = (W+1)'(X_MIN);
  localparam logic [W:0]        XMAX_E = (W+1)'(X_MAX);
  localparam logic [W:0]        YMIN_E = (W+1)'(Y_MIN);
  localparam logic [W:0]        YMAX_E = (W+1)'(Y_MAX);
  localparam logic signed [W:0] P_STEP = (W+1)'(STEP);
  localparam logic signed [W:0] N_STEP = -P_STEP;
  localparam logic [W-1:0]      Y_RST  = W'((Y_MIN + Y_MAX) / 2);

  logic [W-1:0]        x_q  [N_BALLS];
  logic [W-1:0]        y_q  [N_BALLS];
  logic signed [W:0]   xs_q [N_BALLS];
  logic signed [W:0]   ys_q [N_BALLS];
  logic [W-1:0]        x_d  [N_BALLS];
  logic [W-1:0]        y_d  [N_BALLS];
  logic signed [W:0]   xs_d [N_BALLS];
  logic signed [W:0]   ys_d [N_BALLS];
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [SEL_W-1:0]    hit_id_q, hit_id_d;
  logic                hit_q, hit_d;
  logic                vs_q;
  logic                tick_c;

  assign tick_c = bus.vs & ~vs_q;

  // Frame update: select/steer on the sampled keycode, then bounce overrides per axis.
  always_comb begin
    logic signed [W:0] xs_n;
    logic signed [W:0] ys_n;
    logic [7:0]        kofs;
    xs_n  = '0;
    ys_n  = '0;
    kofs  = bus.keycode - 8'h1E;
    sel_d = sel_q;
    for (int i = 0; i < int'(N_BALLS); i++) begin
      x_d[i]  = x_q[i];
      y_d[i]  = y_q[i];
      xs_d[i] = xs_q[i];
      ys_d[i] = ys_q[i];
    end
    if (tick_c) begin
      if (bus.keycode >= 8'h1E && bus.keycode <= 8'h25 && kofs < 8'(N_BALLS))
        sel_d = SEL_W'(kofs);
      for (int i = 0; i < int'(N_BALLS); i++) begin
        xs_n = xs_q[i];
        ys_n = ys_q[i];
        if (SEL_W'(i) == sel_q) begin
          case (bus.keycode)
            8'h1A:   begin xs_n = '0;     ys_n = N_STEP; end
            8'h16:   begin xs_n = '0;     ys_n = P_STEP; end
            8'h04:   begin xs_n = N_STEP; ys_n = '0;     end
            8'h07:   begin xs_n = P_STEP; ys_n = '0;     end
            default: ;
          endcase
        end
        if ({1'b0, x_q[i]} + BS_E >= XMAX_E)      xs_n = N_STEP;
        else if ({1'b0, x_q[i]} <= XMIN_E + BS_E) xs_n = P_STEP;
        if ({1'b0, y_q[i]} + BS_E >= YMAX_E)      ys_n = N_STEP;
        else if ({1'b0, y_q[i]} <= YMIN_E + BS_E) ys_n = P_STEP;
        xs_d[i] = xs_n;
        ys_d[i] = ys_n;
        x_d[i]  = W'({1'b0, x_q[i]} + xs_n);
        y_d[i]  = W'({1'b0, y_q[i]} + ys_n);
      end
    end
  end

  // Pixel hit-test; descending scan leaves the lowest hitting index.
  always_comb begin
    hit_d    = 1'b0;
    hit_id_d = '0;
    for (int i = int'(N_BALLS) - 1; i >= 0; i--) begin
      if (({1'b0, bus.DrawX} + BS_E >= {1'b0, x_q[i]}) &&
          ({1'b0, bus.DrawX} <= {1'b0, x_q[i]} + BS_E) &&
          ({1'b0, bus.DrawY} + BS_E >= {1'b0, y_q[i]}) &&
          ({1'b0, bus.DrawY} <= {1'b0, y_q[i]} + BS_E)) begin
        hit_d    = 1'b1;
        hit_id_d = SEL_W'(i);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < int'(N_BALLS); i++) begin
        x_q[i]  <= W'(X_MIN + (i + 1) * (X_MAX - X_MIN) / (N_BALLS + 1));
        y_q[i]  <= Y_RST;
        xs_q[i] <= '0;
        ys_q[i] <= '0;
      end
      sel_q    <= '0;
      hit_q    <= 1'b0;
      hit_id_q <= '0;
      vs_q     <= 1'b1;
    end else begin
      for (int i = 0; i < int'(N_BALLS); i++) begin
        x_q[i]  <= x_d[i];
        y_q[i]  <= y_d[i];
        xs_q[i] <= xs_d[i];
        ys_q[i] <= ys_d[i];
      end
      sel_q    <= sel_d;
      hit_q    <= hit_d;
      hit_id_q <= hit_id_d;
      vs_q     <= bus.vs;
    end
  end

  always_comb begin
    bus.BallX = '0;
    bus.BallY = '0;
    for (int i = 0; i < int'(N_BALLS); i++) begin
      bus.BallX[i*W +: W] = x_q[i];
      bus.BallY[i*W +: W] = y_q[i];
    end
  end

  assign bus.BallS  = W'(BALL_S);
  assign bus.sel    = sel_q;
  assign bus.hit    = hit_q;
  assign bus.hit_id = hit_id_q;
endmodule
